// File: rtl/stress_mon_pkg.sv
// Shared types and constants for the stress-result signature monitor.
// The golden signature is the CRC of ASCII "123456789" sent MSB-first from the default seed.
package stress_mon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_t;

   localparam logic [15:0] DEFAULT_POLY = 16'h1021;
   localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;
   localparam logic [15:0] GOLDEN_SIG   = 16'h29B1;

endpackage

// File: rtl/crc_bitstep.sv
// One-bit CRC update, MSB-first, normal-form polynomial, no reflection.
// Purely combinational so the top can absorb one sample per clock.
module crc_bitstep #(
   parameter int SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY = 16'h1021
)(
   input  logic [SIG_W-1:0] sig,
   input  logic             data,
   output logic [SIG_W-1:0] next_sig
);

   logic fb;

   assign fb       = sig[SIG_W-1] ^ data;
   assign next_sig = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/stress_monitor.sv
// Compacts the stress block's output bit over a fixed window into a CRC signature
// and a toggle count, then presents the result on a valid/ready handshake.
module stress_monitor
   import stress_mon_pkg::*;
#(
   parameter int WINDOW = 1024,
   parameter int SIG_W  = 16,
   parameter logic [SIG_W-1:0] POLY = SIG_W'(DEFAULT_POLY),
   parameter logic [SIG_W-1:0] SEED = SIG_W'(DEFAULT_SEED),
   parameter int HB_W   = 24,
   parameter int CNT_W  = $clog2(WINDOW)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             start,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SIG_W-1:0] res_signature,
   output logic [CNT_W-1:0] res_toggles,
   output logic             led
);

   state_t             state;
   state_t             state_next;
   logic               din_q;
   logic               prev;
   logic [SIG_W-1:0]   sig;
   logic [SIG_W-1:0]   next_sig;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   tog;
   logic [CNT_W-1:0]   tog_next;
   logic [HB_W-1:0]    hb;
   logic               last;
   logic               load;
   logic               tog_inc;

   crc_bitstep #(
      .SIG_W (SIG_W),
      .POLY  (POLY)
   ) u_bitstep (
      .sig      (sig),
      .data     (din_q),
      .next_sig (next_sig)
   );

   // The first sample of a window only seeds prev; it never counts as a transition.
   assign tog_inc  = (cnt != '0) && (din_q != prev);
   assign tog_next = tog + {{(CNT_W-1){1'b0}}, tog_inc};
   assign last     = (cnt == CNT_W'(WINDOW - 1));
   assign load     = start && ((state == IDLE) || ((state == HOLD) && res_ready));

   assign busy      = (state != IDLE);
   assign res_valid = (state == HOLD);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last) state_next = HOLD;
         HOLD:    if (res_ready) state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Datapath: results latch on the RUN->HOLD edge so the last sample is included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_q         <= 1'b0;
         hb            <= '0;
         sig           <= '0;
         cnt           <= '0;
         tog           <= '0;
         prev          <= 1'b0;
         res_signature <= '0;
         res_toggles   <= '0;
      end else begin
         din_q <= din;
         hb    <= hb + HB_W'(1);
         if (load) begin
            sig  <= SEED;
            cnt  <= '0;
            tog  <= '0;
            prev <= 1'b0;
         end else if (state == RUN) begin
            sig  <= next_sig;
            cnt  <= cnt + CNT_W'(1);
            tog  <= tog_next;
            prev <= din_q;
            if (last) begin
               res_signature <= next_sig;
               res_toggles   <= tog_next;
            end
         end
      end
   end

   always_comb begin
      led = 1'b0;
      case (state)
         IDLE:    led = hb[HB_W-1];
         RUN:     led = 1'b1;
         HOLD:    led = res_signature[0];
         default: led = 1'b0;
      endcase
   end

endmodule
